// File: rtl/ram_dp_init.sv
// Simple-dual-port synchronous RAM: byte-masked write port, pipelined read port,
// selectable read-during-write behaviour and a post-reset clear sweep.
module ram_dp_init #(
    parameter int                    DATA_WIDTH   = 8,
    parameter int                    ADDR_WIDTH   = 10,
    parameter int                    READ_LATENCY = 1,
    parameter int                    RDW_MODE     = 0,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = {DATA_WIDTH{1'b0}}
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    write_enable,
    input  logic [ADDR_WIDTH-1:0]   write_address,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic [DATA_WIDTH/8-1:0] byte_enable,
    input  logic                    read_enable,
    input  logic [ADDR_WIDTH-1:0]   read_address,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    read_valid,
    output logic                    init_busy
);

    localparam int                    DEPTH         = 2 ** ADDR_WIDTH;
    localparam int                    NUM_BYTES     = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR     = {ADDR_WIDTH{1'b1}};
    localparam logic                  WRITE_THROUGH = (RDW_MODE == 32'sd1) ? 1'b1 : 1'b0;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [NUM_BYTES-1:0]  lane_mask
    );
        logic [DATA_WIDTH-1:0] result;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (lane_mask[i]) begin
                result[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                result[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return result;
    endfunction

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [0:0]            state_r;
    logic [ADDR_WIDTH-1:0] clr_cnt_r;
    logic                  init_busy_r;
    logic                  wr_go_s;
    logic                  rd_go_s;
    logic [DATA_WIDTH-1:0] merged_word_s;
    logic [DATA_WIDTH-1:0] rd_word_s;
    logic                  s1_valid_r;
    logic [DATA_WIDTH-1:0] s1_data_r;

    // Request qualification and read-word selection (old data or write-through merge)
    always_comb begin
        wr_go_s = 1'b0;
        rd_go_s = 1'b0;
        if (!reset && (state_r == ST_READY)) begin
            wr_go_s = write_enable;
            rd_go_s = read_enable;
        end else begin
            wr_go_s = 1'b0;
            rd_go_s = 1'b0;
        end
        merged_word_s = merge_bytes(mem_r[write_address], data_in, byte_enable);
        if (WRITE_THROUGH && wr_go_s && (write_address == read_address)) begin
            rd_word_s = merged_word_s;
        end else begin
            rd_word_s = mem_r[read_address];
        end
    end

    // Storage array: sweep writes while clearing, masked user writes once ready
    always_ff @(posedge clk) begin
        if (!reset && (state_r == ST_CLEAR)) begin
            mem_r[clr_cnt_r] <= INIT_VALUE;
        end else if (wr_go_s) begin
            mem_r[write_address] <= merged_word_s;
        end
    end

    // Clear sequencer: one word per edge, leaves CLEAR on the edge writing the last word
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_CLEAR;
            clr_cnt_r   <= {ADDR_WIDTH{1'b0}};
            init_busy_r <= 1'b1;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    clr_cnt_r <= clr_cnt_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                    if (clr_cnt_r == LAST_ADDR) begin
                        state_r     <= ST_READY;
                        init_busy_r <= 1'b0;
                    end else begin
                        init_busy_r <= 1'b1;
                    end
                end
                ST_READY: begin
                    init_busy_r <= 1'b0;
                end
                default: begin
                    state_r     <= ST_CLEAR;
                    clr_cnt_r   <= {ADDR_WIDTH{1'b0}};
                    init_busy_r <= 1'b1;
                end
            endcase
        end
    end

    // First read stage; data holds between reads
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_r <= 1'b0;
            s1_data_r  <= {DATA_WIDTH{1'b0}};
        end else begin
            s1_valid_r <= rd_go_s;
            if (rd_go_s) begin
                s1_data_r <= rd_word_s;
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                  out_valid_r;
            logic [DATA_WIDTH-1:0] out_data_r;

            // Extra output register stage for the two-cycle latency build
            always_ff @(posedge clk) begin
                if (reset) begin
                    out_valid_r <= 1'b0;
                    out_data_r  <= {DATA_WIDTH{1'b0}};
                end else begin
                    out_valid_r <= s1_valid_r;
                    if (s1_valid_r) begin
                        out_data_r <= s1_data_r;
                    end
                end
            end

            assign data_out   = out_data_r;
            assign read_valid = out_valid_r;
        end else begin : g_lat1
            assign data_out   = s1_data_r;
            assign read_valid = s1_valid_r;
        end
    endgenerate

    assign init_busy = init_busy_r;

endmodule

// File: tb/tb_ram_dp_init.sv
// Directed bench for ram_dp_init: default build, a 16-bit write-through build and a
// two-cycle-latency build with a non-zero clear value.
module tb_ram_dp_init;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Instance A: defaults (8 bit, 1024 words, latency 1, old data on collision)
    logic       a_reset = 1'b1, a_we = 1'b0, a_re = 1'b0;
    logic [9:0] a_wa = 10'd0, a_ra = 10'd0;
    logic [7:0] a_di = 8'd0, a_do;
    logic [0:0] a_be = 1'b1;
    logic       a_rv, a_busy;

    ram_dp_init u_a (
        .clk(clk), .reset(a_reset), .write_enable(a_we), .write_address(a_wa),
        .data_in(a_di), .byte_enable(a_be), .read_enable(a_re), .read_address(a_ra),
        .data_out(a_do), .read_valid(a_rv), .init_busy(a_busy)
    );

    // Instance B: 16 bit, 16 words, write-through on collision
    logic        b_reset = 1'b1, b_we = 1'b0, b_re = 1'b0;
    logic [3:0]  b_wa = 4'd0, b_ra = 4'd0;
    logic [15:0] b_di = 16'd0, b_do;
    logic [1:0]  b_be = 2'b11;
    logic        b_rv, b_busy;

    ram_dp_init #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .RDW_MODE(1)) u_b (
        .clk(clk), .reset(b_reset), .write_enable(b_we), .write_address(b_wa),
        .data_in(b_di), .byte_enable(b_be), .read_enable(b_re), .read_address(b_ra),
        .data_out(b_do), .read_valid(b_rv), .init_busy(b_busy)
    );

    // Instance C: latency 2, 16 words, clear value 0xFF
    logic       c_reset = 1'b1, c_we = 1'b0, c_re = 1'b0;
    logic [3:0] c_wa = 4'd0, c_ra = 4'd0;
    logic [7:0] c_di = 8'd0, c_do;
    logic [0:0] c_be = 1'b1;
    logic       c_rv, c_busy;

    ram_dp_init #(.ADDR_WIDTH(4), .READ_LATENCY(2), .INIT_VALUE(8'hFF)) u_c (
        .clk(clk), .reset(c_reset), .write_enable(c_we), .write_address(c_wa),
        .data_in(c_di), .byte_enable(c_be), .read_enable(c_re), .read_address(c_ra),
        .data_out(c_do), .read_valid(c_rv), .init_busy(c_busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        int cnt;
        logic saw_rv;
        logic [7:0] exp_c [3];
        exp_c[0] = 8'hA1;
        exp_c[1] = 8'hB2;
        exp_c[2] = 8'hC3;

        // ---------------- Instance A ----------------
        tick;
        chk("a_rst_busy", a_busy, 1);
        chk("a_rst_rv", a_rv, 0);
        chk("a_rst_do", a_do, 0);
        a_reset = 1'b0;
        cnt = 0;
        for (int k = 1; k <= 1100; k++) begin
            tick;
            if (!a_busy) begin
                cnt = k;
                break;
            end
        end
        chk("a_sweep_edges", cnt, 1024);

        a_re = 1'b1; a_ra = 10'd0;    tick; chk("a_rd0_rv", a_rv, 1);    chk("a_rd0_do", a_do, 0);
        a_ra = 10'd511;               tick; chk("a_rd511_rv", a_rv, 1);  chk("a_rd511_do", a_do, 0);
        a_ra = 10'd1023;              tick; chk("a_rd1023_rv", a_rv, 1); chk("a_rd1023_do", a_do, 0);
        a_re = 1'b0;                  tick; chk("a_idle_rv", a_rv, 0);

        a_we = 1'b1; a_wa = 10'd55; a_di = 8'h56; tick;
        a_wa = 10'd66; a_di = 8'h36;              tick;
        a_we = 1'b0; a_re = 1'b1; a_ra = 10'd66;  tick;
        chk("a_b2b_rv0", a_rv, 1); chk("a_b2b_do0", a_do, 8'h36);
        a_ra = 10'd55;                            tick;
        chk("a_b2b_rv1", a_rv, 1); chk("a_b2b_do1", a_do, 8'h56);
        a_re = 1'b0;                              tick;
        chk("a_hold_rv", a_rv, 0); chk("a_hold_do", a_do, 8'h56);

        a_we = 1'b1; a_wa = 10'd7; a_di = 8'h11;  tick;
        a_di = 8'h22; a_re = 1'b1; a_ra = 10'd7;  tick;
        chk("a_rdw_old", a_do, 8'h11);
        a_we = 1'b0;                              tick;
        chk("a_rdw_after", a_do, 8'h22);
        a_we = 1'b1; a_wa = 10'd8; a_di = 8'h99; a_ra = 10'd55; tick;
        chk("a_diff_addr", a_do, 8'h56);
        a_we = 1'b0; a_ra = 10'd8;                tick;
        chk("a_diff_wr", a_do, 8'h99);
        a_re = 1'b0;

        // ---------------- Instance B ----------------
        b_reset = 1'b0;
        cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            tick;
            if (!b_busy) begin
                cnt = k;
                break;
            end
        end
        chk("b_sweep_edges", cnt, 16);
        b_we = 1'b1; b_wa = 4'd3; b_di = 16'hABCD; b_be = 2'b11; tick;
        b_di = 16'h1234; b_be = 2'b01;                           tick;
        b_we = 1'b0; b_re = 1'b1; b_ra = 4'd3;                   tick;
        chk("b_be01", b_do, 16'hAB34);
        b_re = 1'b0; b_we = 1'b1; b_di = 16'h5555; b_be = 2'b00; tick;
        b_we = 1'b0; b_re = 1'b1;                                tick;
        chk("b_be00", b_do, 16'hAB34);
        b_re = 1'b0; b_we = 1'b1; b_wa = 4'd7; b_di = 16'h0011; b_be = 2'b11; tick;
        b_di = 16'h0022; b_re = 1'b1; b_ra = 4'd7;               tick;
        chk("b_rdw_new", b_do, 16'h0022);
        b_di = 16'h3344; b_be = 2'b10;                           tick;
        chk("b_rdw_merge", b_do, 16'h3322);
        b_we = 1'b0;                                             tick;
        chk("b_rdw_after", b_do, 16'h3322);
        b_re = 1'b0;

        // ---------------- Instance C ----------------
        c_reset = 1'b0;
        for (int k = 0; k < 9; k++) tick;
        c_we = 1'b1; c_wa = 4'd5; c_di = 8'h00; c_re = 1'b1; c_ra = 4'd5;
        c_reset = 1'b1; tick;
        chk("c_mid_rst_busy", c_busy, 1);
        c_reset = 1'b0;
        cnt = 0;
        saw_rv = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tick;
            saw_rv = saw_rv | c_rv;
            if (!c_busy) begin
                cnt = k;
                break;
            end
        end
        c_we = 1'b0; c_re = 1'b0;
        chk("c_sweep_edges", cnt, 16);
        tick;
        saw_rv = saw_rv | c_rv;
        chk("c_sweep_no_rv", saw_rv, 0);

        for (int i = 0; i < 18; i++) begin
            c_re = (i < 16); c_ra = 4'(i);
            tick;
            if (i >= 1 && i <= 16) begin
                chk("c_fill_rv", c_rv, 1);
                chk("c_fill_do", c_do, 8'hFF);
            end else begin
                chk("c_fill_idle", c_rv, 0);
            end
        end
        c_re = 1'b0;

        c_we = 1'b1;
        for (int i = 0; i < 3; i++) begin
            c_wa = 4'(i); c_di = exp_c[i]; tick;
        end
        c_we = 1'b0;
        for (int i = 0; i < 5; i++) begin
            c_re = (i < 3); c_ra = 4'(i);
            tick;
            if (i >= 1 && i <= 3) begin
                chk("c_lat2_rv", c_rv, 1);
                chk("c_lat2_do", c_do, exp_c[i-1]);
            end else begin
                chk("c_lat2_idle", c_rv, 0);
            end
        end

        c_re = 1'b1; c_ra = 4'd1; tick;
        chk("c_flush_pre", c_rv, 0);
        c_reset = 1'b1; tick;
        chk("c_flush_rv", c_rv, 0);
        chk("c_flush_do", c_do, 0);
        chk("c_flush_busy", c_busy, 1);
        c_re = 1'b0; c_reset = 1'b0; tick;
        chk("c_flush_rv2", c_rv, 0);
        tick;
        chk("c_flush_rv3", c_rv, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
